// File: rtl/mmio_controller.sv
// mmio_controller: 16-word IO window with synchronised sticky-flag inputs, output registers, irq mask and memory pass-through.
// Optional input debouncing is enabled by defining MMIO_DEBOUNCE_EN.
module mmio_controller #(
    parameter logic [15:0] IO_BASE         = 16'hFFF0,
    parameter int          N_IN            = 2,
    parameter int          IN_W            = 8,
    parameter int          N_OUT           = 2,
    parameter int          OUT_W           = 8,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            write_data_a,
    input  logic [15:0]            write_data_b,
    input  logic [15:0]            address_a,
    input  logic [15:0]            address_b,
    input  logic                   write_enable_a,
    input  logic                   write_enable_b,
    input  logic [N_IN*IN_W-1:0]   io_in,
    output logic [N_OUT*OUT_W-1:0] io_out,
    output logic [15:0]            read_data_a,
    output logic [15:0]            read_data_b,
    output logic                   irq
);
    localparam int DW = N_IN * IN_W;
    localparam int WW = $clog2(SYNC_STAGES + 2);

    if (IO_BASE[3:0] != 4'd0 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("mmio_controller: illegal parameter combination");
    end

    logic [DW-1:0]          sync_q [SYNC_STAGES];
    logic [DW-1:0]          vis_q, vis_d, cand;
    logic [N_IN-1:0]        flags_q, mask_q, changed, stable;
    logic [N_OUT*OUT_W-1:0] out_q;
    logic [WW-1:0]          warm_q;
    logic                   irq_q;
    logic [15:0]            mem [0:65535];
    logic [15:0]            io_reg [16];
    logic [15:0]            mem_a_q, mem_b_q, io_a_q, io_b_q;
    logic                   hit_a_q, hit_b_q;
    logic                   hit_a, hit_b, wr_a, wr_b, clr;
    logic [3:0]             off_a, off_b;

    assign hit_a = address_a[15:4] == IO_BASE[15:4];
    assign hit_b = address_b[15:4] == IO_BASE[15:4];
    assign off_a = address_a[3:0];
    assign off_b = address_b[3:0];
    assign wr_a  = write_enable_a && hit_a;
    assign wr_b  = write_enable_b && hit_b;
    // Every cycle is a read, so any STATUS access on either port clears once.
    assign clr   = (hit_a && off_a == 4'd8) || (hit_b && off_b == 4'd8);

`ifdef MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] prev_q;
    logic [CW-1:0] cnt_q [N_IN];
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '0;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
            for (int i = 0; i < N_IN; i++)
                cnt_q[i] <= sync_q[SYNC_STAGES-1][i*IN_W +: IN_W] != prev_q[i*IN_W +: IN_W] ? '0 :
                            cnt_q[i] == CW'(DEBOUNCE_CYCLES) ? cnt_q[i] : cnt_q[i] + CW'(1);
        end
    end
    assign cand = prev_q;
    always_comb begin
        stable = '0;
        for (int i = 0; i < N_IN; i++) stable[i] = cnt_q[i] == CW'(DEBOUNCE_CYCLES);
    end
`else
    assign cand   = sync_q[SYNC_STAGES-1];
    assign stable = '1;
`endif

    always_comb begin
        vis_d   = vis_q;
        changed = '0;
        for (int i = 0; i < N_IN; i++) begin
            changed[i] = stable[i] && cand[i*IN_W +: IN_W] != vis_q[i*IN_W +: IN_W];
            if (changed[i]) vis_d[i*IN_W +: IN_W] = cand[i*IN_W +: IN_W];
        end
    end

    always_comb begin
        for (int k = 0; k < 16; k++) io_reg[k] = '0;
        for (int k = 0; k < N_IN; k++) io_reg[k] = 16'(vis_q[k*IN_W +: IN_W]);
        io_reg[8] = 16'(flags_q);
        for (int k = 0; k < N_OUT; k++) io_reg[9+k] = 16'(out_q[k*OUT_W +: OUT_W]);
        io_reg[15] = 16'(mask_q);
    end

    // Port B is applied first so port A wins on a same-register collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            vis_q   <= '0;
            flags_q <= '0;
            mask_q  <= '0;
            out_q   <= '0;
            irq_q   <= 1'b0;
            warm_q  <= WW'(SYNC_STAGES + 1);
            hit_a_q <= 1'b0;
            hit_b_q <= 1'b0;
            io_a_q  <= '0;
            io_b_q  <= '0;
            mem_a_q <= '0;
            mem_b_q <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            vis_q   <= vis_d;
            warm_q  <= warm_q == '0 ? warm_q : warm_q - WW'(1);
            flags_q <= (flags_q & ~{N_IN{clr}}) | (warm_q == '0 ? changed : '0);
            irq_q   <= |(flags_q & mask_q);
            hit_a_q <= hit_a;
            hit_b_q <= hit_b;
            io_a_q  <= io_reg[off_a];
            io_b_q  <= io_reg[off_b];
            mem_a_q <= mem[address_a];
            mem_b_q <= mem[address_b];
            if (wr_b && off_b == 4'd15) mask_q <= write_data_b[N_IN-1:0];
            if (wr_a && off_a == 4'd15) mask_q <= write_data_a[N_IN-1:0];
            for (int j = 0; j < N_OUT; j++) begin
                if (wr_b && off_b == 4'(9 + j)) out_q[j*OUT_W +: OUT_W] <= write_data_b[OUT_W-1:0];
                if (wr_a && off_a == 4'(9 + j)) out_q[j*OUT_W +: OUT_W] <= write_data_a[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (write_enable_b && !hit_b) mem[address_b] <= write_data_b;
            if (write_enable_a && !hit_a) mem[address_a] <= write_data_a;
        end
    end

    assign io_out      = out_q;
    assign irq         = irq_q;
    assign read_data_a = hit_a_q ? io_a_q : mem_a_q;
    assign read_data_b = hit_b_q ? io_b_q : mem_b_q;
endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed plus randomized checks of mmio_controller against a behavioural model.
module tb_mmio_controller;
    localparam logic [15:0] IO_BASE = 16'hFFF0;
    localparam int N_IN = 2, IN_W = 8, N_OUT = 2, OUT_W = 8, SYNC = 2, DB = 4;
    localparam int DW = N_IN * IN_W;
    localparam int HD = SYNC + DB + 2;

    logic clock = 1'b0;
    logic reset;
    logic [15:0] write_data_a, write_data_b, address_a, address_b;
    logic write_enable_a, write_enable_b;
    logic [DW-1:0] io_in;
    logic [N_OUT*OUT_W-1:0] io_out;
    logic [15:0] read_data_a, read_data_b;
    logic irq;

    int total = 0;
    int bad = 0;

    mmio_controller #(.IO_BASE(IO_BASE), .N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .OUT_W(OUT_W),
                      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB)) dut (
        .clock(clock), .reset(reset),
        .write_data_a(write_data_a), .write_data_b(write_data_b),
        .address_a(address_a), .address_b(address_b),
        .write_enable_a(write_enable_a), .write_enable_b(write_enable_b),
        .io_in(io_in), .io_out(io_out),
        .read_data_a(read_data_a), .read_data_b(read_data_b), .irq(irq)
    );

    always #5 clock = ~clock;

    // Reference model state: history of sampled io_in (h[0] newest), register file, sparse memory.
    logic [DW-1:0]    h [HD];
    logic [DW-1:0]    vis_m, nvis_m;
    logic [N_IN-1:0]  flags_m, mask_m, chg_m;
    logic [OUT_W-1:0] out_m [N_OUT];
    logic [15:0]      mem_m [int];
    logic [15:0]      exp_a, exp_b;
    logic [16:0]      r_m;
    logic [IN_W-1:0]  c_m;
    logic             irq_m, nirq_m, ka, kb, st_m, clr_m;
    int               warm_m;
    bit               started = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] model_rd(input logic [15:0] a);
        int o;
        o = int'(a[3:0]);
        if (a[15:4] != IO_BASE[15:4]) return mem_m.exists(int'(a)) ? {1'b1, mem_m[int'(a)]} : 17'd0;
        if (o < N_IN) return {1'b1, 16'(vis_m[o*IN_W +: IN_W])};
        if (o == 8) return {1'b1, 16'(flags_m)};
        if (o >= 9 && o < 9 + N_OUT) return {1'b1, 16'(out_m[o-9])};
        if (o == 15) return {1'b1, 16'(mask_m)};
        return {1'b1, 16'h0000};
    endfunction

    task automatic mwrite(input logic [15:0] a, input logic [15:0] d);
        int o;
        o = int'(a[3:0]);
        if (a[15:4] != IO_BASE[15:4]) mem_m[int'(a)] = d;
        else if (o == 15) mask_m = d[N_IN-1:0];
        else if (o >= 9 && o < 9 + N_OUT) out_m[o-9] = d[OUT_W-1:0];
    endtask

    always @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < HD; j++) h[j] = '0;
            vis_m = '0; flags_m = '0; mask_m = '0; irq_m = 1'b0;
            for (int j = 0; j < N_OUT; j++) out_m[j] = '0;
            warm_m = SYNC + 1;
            exp_a = '0; exp_b = '0; ka = 1'b1; kb = 1'b1;
        end else begin
            r_m = model_rd(address_a); ka = r_m[16]; exp_a = r_m[15:0];
            r_m = model_rd(address_b); kb = r_m[16]; exp_b = r_m[15:0];
            nirq_m = |(flags_m & mask_m);
            for (int j = HD - 1; j > 0; j--) h[j] = h[j-1];
            h[0] = io_in;
            chg_m = '0;
            nvis_m = vis_m;
            for (int i = 0; i < N_IN; i++) begin
`ifdef MMIO_DEBOUNCE_EN
                c_m = h[SYNC+1][i*IN_W +: IN_W];
                st_m = 1'b1;
                for (int d = 1; d <= DB; d++) if (h[SYNC+1+d][i*IN_W +: IN_W] != c_m) st_m = 1'b0;
`else
                c_m = h[SYNC][i*IN_W +: IN_W];
                st_m = 1'b1;
`endif
                if (st_m && c_m != vis_m[i*IN_W +: IN_W]) begin
                    chg_m[i] = 1'b1;
                    nvis_m[i*IN_W +: IN_W] = c_m;
                end
            end
            clr_m = (address_a[15:4] == IO_BASE[15:4] && address_a[3:0] == 4'd8) ||
                    (address_b[15:4] == IO_BASE[15:4] && address_b[3:0] == 4'd8);
            if (clr_m) flags_m = '0;
            if (warm_m == 0) flags_m = flags_m | chg_m;
            vis_m = nvis_m;
            if (warm_m > 0) warm_m--;
            irq_m = nirq_m;
            if (write_enable_b) mwrite(address_b, write_data_b);
            if (write_enable_a) mwrite(address_a, write_data_a);
        end
        started = 1;
    end

    always @(negedge clock) begin
        logic [N_OUT*OUT_W-1:0] po;
        if (started) begin
            for (int j = 0; j < N_OUT; j++) po[j*OUT_W +: OUT_W] = out_m[j];
            if (ka) chk("model_rd_a", read_data_a, exp_a);
            if (kb) chk("model_rd_b", read_data_b, exp_b);
            chk("model_io_out", 16'(io_out), 16'(po));
            chk("model_irq", 16'(irq), 16'(irq_m));
        end
    end

    task automatic drive(input logic [15:0] aa, input logic [15:0] da, input logic wa,
                         input logic [15:0] ab, input logic [15:0] db, input logic wb);
        address_a = aa; write_data_a = da; write_enable_a = wa;
        address_b = ab; write_data_b = db; write_enable_b = wb;
        @(negedge clock);
    endtask

    task automatic rd(input logic [15:0] aa, input logic [15:0] ab);
        drive(aa, 16'h0, 1'b0, ab, 16'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) rd(16'h0200, 16'h0201);
    endtask

    function automatic logic [15:0] raddr();
        int s;
        s = $urandom_range(0, 3);
        return s < 2 ? {IO_BASE[15:4], 4'($urandom_range(0, 15))} :
               s == 2 ? 16'h0100 + 16'($urandom_range(0, 7)) : IO_BASE + 16'd8;
    endfunction

    initial begin
        reset = 1'b1;
        io_in = 16'hA55A;
        address_a = 16'h0200; address_b = 16'h0201;
        write_data_a = '0; write_data_b = '0;
        write_enable_a = 1'b0; write_enable_b = 1'b0;
        @(negedge clock);
        idle(2);
        chk("rst_rd_a", read_data_a, 16'h0000);
        chk("rst_rd_b", read_data_b, 16'h0000);
        chk("rst_io_out", 16'(io_out), 16'h0000);
        chk("rst_irq", 16'(irq), 16'h0000);
        reset = 1'b0;
        idle(10);
        rd(16'hFFF0, 16'hFFF1);
        chk("ch0_val", read_data_a, 16'h005A);
        chk("ch1_val", read_data_b, 16'h00A5);
        rd(16'hFFF8, 16'hFFF8);
`ifndef MMIO_DEBOUNCE_EN
        chk("warmup_status_a", read_data_a, 16'h0000);
        chk("warmup_status_b", read_data_b, 16'h0000);
`endif
        drive(16'hFFF9, 16'h12C3, 1'b1, 16'hFFF9, 16'h0077, 1'b1);
        chk("out0_port_a_wins", 16'(io_out[7:0]), 16'h00C3);
        rd(16'hFFF9, 16'h0201);
        chk("out0_readback", read_data_a, 16'h00C3);

        drive(16'hFFFF, 16'h0002, 1'b1, 16'h0201, 16'h0, 1'b0);
        io_in[15:8] = 8'h00;
        idle(3);
`ifndef MMIO_DEBOUNCE_EN
        chk("irq_lag", 16'(irq), 16'h0000);
`endif
        idle(1);
`ifndef MMIO_DEBOUNCE_EN
        chk("irq_rise", 16'(irq), 16'h0001);
`endif
        rd(16'hFFF8, 16'h0201);
`ifndef MMIO_DEBOUNCE_EN
        chk("status_bit1", read_data_a, 16'h0002);
        chk("irq_held", 16'(irq), 16'h0001);
`endif
        rd(16'hFFF8, 16'h0201);
`ifndef MMIO_DEBOUNCE_EN
        chk("status_cleared", read_data_a, 16'h0000);
        chk("irq_fall", 16'(irq), 16'h0000);
`endif
        idle(12);
        rd(16'hFFF8, 16'hFFF8);

        io_in[15:8] = 8'h11;
        idle(4);
        io_in[7:0] = 8'h33;
        idle(2);
        rd(16'hFFF8, 16'h0201);
`ifndef MMIO_DEBOUNCE_EN
        chk("status_pre_clear", read_data_a, 16'h0002);
`endif
        rd(16'hFFF8, 16'h0201);
`ifndef MMIO_DEBOUNCE_EN
        chk("status_set_wins", read_data_a, 16'h0001);
`endif
        rd(16'hFFF8, 16'h0201);
`ifndef MMIO_DEBOUNCE_EN
        chk("status_final", read_data_a, 16'h0000);
`endif
        idle(12);
        rd(16'hFFF8, 16'hFFF8);

        drive(16'h0100, 16'hBEEF, 1'b1, 16'h0201, 16'h0, 1'b0);
        rd(16'hFFF0, 16'h0100);
        chk("mem_readback", read_data_b, 16'hBEEF);
        chk("io_interleave", read_data_a, 16'h0033);

`ifdef MMIO_DEBOUNCE_EN
        io_in[7:0] = 8'hCC;
        idle(2);
        io_in[7:0] = 8'h33;
        idle(12);
        rd(16'hFFF0, 16'hFFF8);
        chk("glitch_val", read_data_a, 16'h0033);
        chk("glitch_flag", read_data_b, 16'h0000);
        io_in[7:0] = 8'hCC;
        idle(12);
        rd(16'hFFF0, 16'hFFF8);
        chk("debounced_val", read_data_a, 16'h00CC);
        chk("debounced_flag", read_data_b, 16'h0001);
`endif

        repeat (3000) begin
            reset = $urandom_range(0, 399) == 0;
            if ($urandom_range(0, 5) == 0) io_in = 16'($urandom);
            drive(raddr(), 16'($urandom), $urandom_range(0, 2) == 0,
                  raddr(), 16'($urandom), $urandom_range(0, 2) == 0);
        end
        reset = 1'b0;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmio_controller.md
Name: mmio_controller

Overview:
- Parametrised memory-mapped IO block. Sits between the CPU's two data ports and the `memory` instance, and is the successor to the fixed 8-bit, read-only IO mux.
- Decodes a 16-word IO window. Provides N_IN synchronised input channels with sticky change flags (clear-on-read), N_OUT writable output registers, an interrupt-enable mask and a registered irq.
- All other addresses pass through to `memory`.

Parameters:
- IO_BASE, 16'hFFF0, base of the 16-word IO window; low 4 bits must be 0.
- N_IN, 2, number of input channels, 1..8.
- IN_W, 8, input channel width, 1..16.
- N_OUT, 2, number of output registers, 1..6.
- OUT_W, 8, output register width, 1..16.
- SYNC_STAGES, 2, synchroniser depth on io_in, >=2.
- DEBOUNCE_CYCLES, 4, stable cycles required; used only with MMIO_DEBOUNCE_EN.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- write_data_a, input, 16, port A write data.
- write_data_b, input, 16, port B write data.
- address_a, input, 16, port A word address.
- address_b, input, 16, port B word address.
- write_enable_a, input, 1, port A write strobe.
- write_enable_b, input, 1, port B write strobe.
- io_in, input, N_IN*IN_W, asynchronous external inputs; channel i at [i*IN_W +: IN_W].
- io_out, output, N_OUT*OUT_W, output register contents; register j at [j*OUT_W +: OUT_W].
- read_data_a, output, 16, port A read data.
- read_data_b, output, 16, port B read data.
- irq, output, 1, registered OR of (flags & mask).

Behaviour:
- One clock domain, with the clock and reset ports named as above (`clock`, `reset`); reset is synchronous and active-high.
- Reset clears all synchroniser stages, visible input values, flags, output registers, mask, irq and read_data_a/b to 0. It also loads the warm-up counter with SYNC_STAGES+1.
- Window: address[15:4]==IO_BASE[15:4]. The offset is address[3:0].
- Register map:
  - offsets 0..N_IN-1: input channel value, zero-extended, read-only.
  - offset 8: STATUS; bit i = change flag i. Read-only, and any read clears the flags.
  - offsets 9..9+N_OUT-1: output registers, R/W, write takes write_data[OUT_W-1:0].
  - offset 15: MASK[N_IN-1:0], R/W.
  - all other offsets: read 0, writes ignored.
- Memory write enables are gated: a write whose address falls in the window never reaches `memory`. Outside the window, ports pass through unchanged.
- Read latency is 1 cycle on both ports, matching `memory`. The window hit and offset are registered with the address, and read_data selects IO data or memory data in the following cycle. IO read data is sampled in the address cycle.
- Input path: io_in passes through the SYNC_STAGES flop chain into the visible value register. When the new synchronised value differs from the visible value, the visible value updates and flag i is set in the same cycle.
- Warm-up: while the warm-up counter is nonzero it decrements and flag setting is suppressed; the visible values still track. This prevents a spurious flag after reset.
- Flag priority: a set event in the same cycle as a clearing STATUS read leaves the flag set. The read returns the pre-clear value. Reads from both ports in the same cycle clear once, and both return the same value.
- Simultaneous writes to the same output register or MASK: port A wins. Writes to different registers both take effect.
- Writes take effect at the next edge. A read of the same register in the cycle after the write returns the new value.
- irq = |(flags & mask), registered, with one cycle of lag after the flag or mask changes.
- Reset asserted mid-operation overrides every write and read in that cycle.

Optional Feature:
- Macro name: MMIO_DEBOUNCE_EN.
- When defined, each channel has a stability counter of width clog2(DEBOUNCE_CYCLES+1). The counter resets to 0 whenever the synchronised value differs from the previous synchronised sample.
- The visible value updates, and the flag is set, only once the counter reaches DEBOUNCE_CYCLES.
- When not defined, there are no counters and the visible value follows the synchroniser output directly.

Test Plan:
- Reset, then io_in=16'hA55A (N_IN=2, IN_W=8) held 10 cycles, then read offset 0 (address FFF0) on port A and offset 1 (address FFF1) on port B. Required: read_data_a=16'h005A and read_data_b=16'h00A5 one cycle later; STATUS reads 0 because the change fell inside warm-up.
- Write FFF9=16'h12C3 on port A and, in the same cycle, FFF9=16'h0077 on port B. Required: io_out[7:0]=8'hC3; memory at 16'hFFF9 unchanged; the next read of FFF9 returns 16'h00C3.
- After warm-up, change channel 1 from 8'hA5 to 8'h00 with MASK=16'h0002 written. Required: STATUS bit1 set SYNC_STAGES cycles after the change; irq high one cycle later; a read of FFF8 returns 16'h0002, then the next read returns 0 and irq falls.
- Change channel 0 in the exact cycle the STATUS read's flag clear takes effect. Required: that read returns the pre-clear value and bit0 remains set afterwards.
- Write address 16'h0100=16'hBEEF, then read it back on port B. Required: 16'hBEEF after 1 cycle; interleaved IO reads on port A are unaffected.
- With MMIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: toggle channel 0 for 2 cycles and release it. Required: no visible change and no flag. Hold a new value for 6 cycles. Required: the value appears and the flag sets.
